conv_1x1_stream_feeder: RTL and testbench

//  Transmit side of the conv 1x1 pixel/weight stream. Reads feature-map words and weights from two

---
 rtl/conv_1x1_stream_feeder.sv | 166 ++++++++++++++++
 tb/tb_conv_1x1_stream_feeder.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_1x1_stream_feeder.sv
// Purpose: feeds paired (pixel, weight) beats to the conv 1x1 core, order co > ci > p.
// Latency: start sampled at E0 -> first read issued the next cycle -> valid_out after E2.
// Backpressure: out_ready stalls the output. A 2-entry store (output reg + skid) plus issue gating absorbs the read latency.
//
// Ports:
//   clk, reset                      clock and synchronous active-high reset
//   start / busy / done             pass control: start pulse; busy for the whole pass; 1-cycle done pulse
//   pxl_rd_* / wgt_rd_*             read ports of two sync-read memories (data one cycle after rd_en)
//   pxl_out / weight_out / valid_*  output beat to the core, handshaked with out_ready
module conv_1x1_stream_feeder #(
    parameter int DATA_WIDTH      = 32,
    parameter int IMAGE_WIDTH     = 16,
    parameter int IMAGE_HEIGHT    = 16,
    parameter int CHANNEL_NUM_IN  = 256,
    parameter int CHANNEL_NUM_OUT = 512,
    parameter int PXL_ADDR_WIDTH  = 16,
    parameter int WGT_ADDR_WIDTH  = 17
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic                      pxl_rd_en,
    output logic [PXL_ADDR_WIDTH-1:0] pxl_rd_addr,
    input  logic [DATA_WIDTH-1:0]     pxl_rd_data,
    output logic                      wgt_rd_en,
    output logic [WGT_ADDR_WIDTH-1:0] wgt_rd_addr,
    input  logic [DATA_WIDTH-1:0]     wgt_rd_data,
    output logic [DATA_WIDTH-1:0]     pxl_out,
    output logic                      valid_out,
    output logic [DATA_WIDTH-1:0]     weight_out,
    output logic                      valid_weight_out,
    input  logic                      out_ready
);

    localparam int NPIX = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int P_W  = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int CI_W = (CHANNEL_NUM_IN > 1) ? $clog2(CHANNEL_NUM_IN) : 1;
    localparam int CO_W = (CHANNEL_NUM_OUT > 1) ? $clog2(CHANNEL_NUM_OUT) : 1;

    localparam logic [P_W-1:0]  P_MAX  = P_W'(NPIX - 1);
    localparam logic [CI_W-1:0] CI_MAX = CI_W'(CHANNEL_NUM_IN - 1);
    localparam logic [CO_W-1:0] CO_MAX = CO_W'(CHANNEL_NUM_OUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                  state;
    logic [P_W-1:0]          p;
    logic [CI_W-1:0]         ci;
    logic [CO_W-1:0]         co;
    logic                    inflight;      // read issued last cycle, data on the bus now
    logic                    skid_vld;
    logic [DATA_WIDTH-1:0]   skid_pxl;
    logic [DATA_WIDTH-1:0]   skid_wgt;

    logic                    pop;
    logic [1:0]              occ_after_pop;
    logic                    issue;
    logic                    last_issue;

    // The output register is the FIFO head and the skid is the second entry.
    // Issue only when the read landing next cycle still has a free slot.
    // Counting this cycle's pop keeps one beat per cycle with out_ready high.
    always_comb begin
        pop           = valid_out & out_ready;
        occ_after_pop = {1'b0, valid_out} + {1'b0, skid_vld} - {1'b0, pop};
        issue         = (state == S_RUN) && ((occ_after_pop + {1'b0, inflight}) < 2'd2);
        last_issue    = issue && (p == P_MAX) && (ci == CI_MAX) && (co == CO_MAX);
    end

    assign pxl_rd_en        = issue;
    assign wgt_rd_en        = issue;
    assign pxl_rd_addr      = PXL_ADDR_WIDTH'(ci) * PXL_ADDR_WIDTH'(NPIX) + PXL_ADDR_WIDTH'(p);
    assign wgt_rd_addr      = WGT_ADDR_WIDTH'(co) * WGT_ADDR_WIDTH'(CHANNEL_NUM_IN) + WGT_ADDR_WIDTH'(ci);
    assign valid_weight_out = valid_out;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            p          <= '0;
            ci         <= '0;
            co         <= '0;
            inflight   <= 1'b0;
            skid_vld   <= 1'b0;
            skid_pxl   <= '0;
            skid_wgt   <= '0;
            pxl_out    <= '0;
            weight_out <= '0;
            valid_out  <= 1'b0;
        end else begin
            inflight <= issue;

            // Output stage: refill from the skid first so that order is kept.
            if (!valid_out || pop) begin
                if (skid_vld) begin
                    pxl_out    <= skid_pxl;
                    weight_out <= skid_wgt;
                    valid_out  <= 1'b1;
                    skid_vld   <= inflight;
                    if (inflight) begin
                        skid_pxl <= pxl_rd_data;
                        skid_wgt <= wgt_rd_data;
                    end
                end else if (inflight) begin
                    pxl_out    <= pxl_rd_data;
                    weight_out <= wgt_rd_data;
                    valid_out  <= 1'b1;
                end else begin
                    valid_out  <= 1'b0;
                end
            end else if (inflight) begin
                // Head is stalled. The issue rule guarantees that the skid is free here.
                skid_pxl <= pxl_rd_data;
                skid_wgt <= wgt_rd_data;
                skid_vld <= 1'b1;
            end

            // Address counters: pixel fastest, then input channel, then output channel.
            if (issue) begin
                if (p == P_MAX) begin
                    p <= '0;
                    if (ci == CI_MAX) begin
                        ci <= '0;
                        co <= (co == CO_MAX) ? '0 : co + 1'b1;
                    end else begin
                        ci <= ci + 1'b1;
                    end
                end else begin
                    p <= p + 1'b1;
                end
            end

            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_RUN;
                        busy  <= 1'b1;
                        p     <= '0;
                        ci    <= '0;
                        co    <= '0;
                    end
                end
                S_RUN: begin
                    if (last_issue) state <= S_DRAIN;
                end
                S_DRAIN: begin
                    // The final beat leaves this cycle, so done lands on the next cycle.
                    if (!inflight && (occ_after_pop == 2'd0)) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_1x1_stream_feeder.sv
// Purpose: randomized self-checking bench for conv_1x1_stream_feeder (2x2 image, 2x2 and 1x1 channels).
// Latency: n/a.
// Backpressure: out_ready driven constant, toggled, stalled and random.
module tb_conv_1x1_stream_feeder;

    localparam int DW   = 32;
    localparam int PAW  = 4;
    localparam int WAW  = 3;
    localparam int NPIX = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start0 = 1'b0, start1 = 1'b0, out_ready = 1'b0;
    always #5 clk = ~clk;

    logic           busy0, done0, prd0, wrd0, vout0, vwout0;
    logic [PAW-1:0] paddr0;
    logic [WAW-1:0] waddr0;
    logic [DW-1:0]  pdat0 = '0, wdat0 = '0, pout0, wout0;
    logic           busy1, done1, prd1, wrd1, vout1, vwout1;
    logic [PAW-1:0] paddr1;
    logic [WAW-1:0] waddr1;
    logic [DW-1:0]  pdat1 = '0, wdat1 = '0, pout1, wout1;

    conv_1x1_stream_feeder #(.DATA_WIDTH(DW), .IMAGE_WIDTH(2), .IMAGE_HEIGHT(2),
        .CHANNEL_NUM_IN(2), .CHANNEL_NUM_OUT(2), .PXL_ADDR_WIDTH(PAW), .WGT_ADDR_WIDTH(WAW)) d0 (
        .clk(clk), .reset(reset), .start(start0), .busy(busy0), .done(done0),
        .pxl_rd_en(prd0), .pxl_rd_addr(paddr0), .pxl_rd_data(pdat0),
        .wgt_rd_en(wrd0), .wgt_rd_addr(waddr0), .wgt_rd_data(wdat0),
        .pxl_out(pout0), .valid_out(vout0), .weight_out(wout0),
        .valid_weight_out(vwout0), .out_ready(out_ready));

    conv_1x1_stream_feeder #(.DATA_WIDTH(DW), .IMAGE_WIDTH(2), .IMAGE_HEIGHT(2),
        .CHANNEL_NUM_IN(1), .CHANNEL_NUM_OUT(1), .PXL_ADDR_WIDTH(PAW), .WGT_ADDR_WIDTH(WAW)) d1 (
        .clk(clk), .reset(reset), .start(start1), .busy(busy1), .done(done1),
        .pxl_rd_en(prd1), .pxl_rd_addr(paddr1), .pxl_rd_data(pdat1),
        .wgt_rd_en(wrd1), .wgt_rd_addr(waddr1), .wgt_rd_data(wdat1),
        .pxl_out(pout1), .valid_out(vout1), .weight_out(wout1),
        .valid_weight_out(vwout1), .out_ready(out_ready));

    // Sync-read memories: pixel mem[i] = i, weight mem[j] = 100 + j.
    logic [DW-1:0] pmem [0:15];
    logic [DW-1:0] wmem [0:7];
    initial begin
        for (int i = 0; i < 16; i++) pmem[i] = DW'(i);
        for (int j = 0; j < 8; j++)  wmem[j] = DW'(100 + j);
    end
    always @(posedge clk) begin
        if (prd0) pdat0 <= pmem[paddr0];
        if (wrd0) wdat0 <= wmem[waddr0];
        if (prd1) pdat1 <= pmem[paddr1];
        if (wrd1) wdat1 <= wmem[waddr1];
    end

    // Observed instance selected by sel.
    int             sel = 0;
    logic           m_busy, m_done, m_prd, m_wrd, m_vout, m_vwout, m_start;
    logic [PAW-1:0] m_paddr;
    logic [WAW-1:0] m_waddr;
    logic [DW-1:0]  m_pout, m_wout;
    always_comb begin
        m_busy = busy0; m_done = done0; m_prd = prd0; m_wrd = wrd0; m_vout = vout0;
        m_vwout = vwout0; m_start = start0; m_paddr = paddr0; m_waddr = waddr0;
        m_pout = pout0; m_wout = wout0;
        if (sel == 1) begin
            m_busy = busy1; m_done = done1; m_prd = prd1; m_wrd = wrd1; m_vout = vout1;
            m_vwout = vwout1; m_start = start1; m_paddr = paddr1; m_waddr = waddr1;
            m_pout = pout1; m_wout = wout1;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: expected read addresses and beats, in stream order.
    int            exp_pa[$];
    int            exp_wa[$];
    logic [DW-1:0] exp_px[$];
    logic [DW-1:0] exp_wt[$];
    int   cyc = 0;
    logic mon_en = 1'b0;
    int   issued, accepted, done_cnt, last_beat_cyc, start_cyc, first_valid_cyc;
    logic first_seen, prev_stall;
    logic [DW-1:0] prev_px, prev_wt;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic build(input int cin, input int cout);
        exp_pa.delete(); exp_wa.delete(); exp_px.delete(); exp_wt.delete();
        for (int co = 0; co < cout; co++)
            for (int ci = 0; ci < cin; ci++)
                for (int p = 0; p < NPIX; p++) begin
                    exp_pa.push_back(ci * NPIX + p);
                    exp_wa.push_back(co * cin + ci);
                    exp_px.push_back(pmem[ci * NPIX + p]);
                    exp_wt.push_back(wmem[co * cin + ci]);
                end
        issued = 0; accepted = 0; done_cnt = 0; last_beat_cyc = -100;
        start_cyc = -1; first_valid_cyc = -1; first_seen = 1'b0; prev_stall = 1'b0;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (m_prd) begin
                check("wgt_rd_en", m_wrd, 1);
                if (exp_pa.size() == 0) check("extra_read", 1, 0);
                else begin
                    check("pxl_rd_addr", m_paddr, exp_pa.pop_front());
                    check("wgt_rd_addr", m_waddr, exp_wa.pop_front());
                end
                issued++;
            end
            if (prev_stall) begin
                check("hold_valid", m_vout, 1);
                check("hold_pxl", m_pout, prev_px);
                check("hold_wgt", m_wout, prev_wt);
            end
            if (m_vout && !first_seen) begin
                first_seen = 1'b1;
                first_valid_cyc = cyc;
            end
            if (m_vout && out_ready) begin
                check("valid_weight_out", m_vwout, 1);
                if (exp_px.size() == 0) check("extra_beat", 1, 0);
                else begin
                    check("pxl_out", m_pout, exp_px.pop_front());
                    check("weight_out", m_wout, exp_wt.pop_front());
                end
                accepted++;
                if (exp_px.size() == 0) last_beat_cyc = cyc;
            end
            check("outstanding_le_2", longint'(issued - accepted <= 2), 1);
            if (m_done) begin
                done_cnt++;
                check("done_timing", cyc, last_beat_cyc + 1);
            end
            if (m_start && !m_busy && !reset && start_cyc < 0) start_cyc = cyc;
            prev_stall = m_vout && !out_ready;
            prev_px = m_pout;
            prev_wt = m_wout;
        end
    end

    // mode: 0 ready high, 1 toggle, 2 random, 3 stall 10 cycles after first valid
    task automatic run_pass(input int s, input int mode, input int restart_at);
        int stall_left;
        sel = s;
        build((s == 1) ? 1 : 2, (s == 1) ? 1 : 2);
        @(posedge clk); #1;
        mon_en = 1'b1;
        if (s == 1) start1 = 1'b1; else start0 = 1'b1;
        out_ready = (mode == 3) ? 1'b0 : 1'b1;
        stall_left = 10;
        for (int k = 0; k < 600 && done_cnt == 0; k++) begin
            @(posedge clk); #1;
            start0 = 1'b0; start1 = 1'b0;
            if (k == restart_at) begin
                if (s == 1) start1 = 1'b1; else start0 = 1'b1;
            end
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = ~out_ready;
                2: out_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (first_seen && stall_left > 0) begin
                        out_ready = 1'b0;
                        stall_left--;
                    end else out_ready = first_seen;
                end
            endcase
        end
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            out_ready = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        mon_en = 1'b0;
        check("done_count", done_cnt, 1);
        check("beats_left", exp_px.size(), 0);
        check("reads_left", exp_pa.size(), 0);
        check("beats_accepted", accepted, (s == 1) ? 4 : 16);
        check("first_valid_latency", first_valid_cyc - start_cyc, 3);
        check("busy_end", m_busy, 0);
    endtask

    task automatic reset_mid_pass();
        int idle_bad;
        sel = 0;
        build(2, 2);
        @(posedge clk); #1;
        mon_en = 1'b1;
        start0 = 1'b1;
        for (int k = 0; k < 300 && accepted < 7; k++) begin
            @(posedge clk); #1;
            start0 = 1'b0;
            out_ready = 1'($urandom_range(0, 1));
        end
        check("reached_beat_7", accepted, 7);
        mon_en = 1'b0;
        reset = 1'b1;
        start0 = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        start0 = 1'b0;
        @(negedge clk);
        check("rst_valid_out", vout0, 0);
        check("rst_pxl_out", pout0, 0);
        check("rst_weight_out", wout0, 0);
        check("rst_busy", busy0, 0);
        check("rst_done", done0, 0);
        check("rst_rd_en", prd0, 0);
        check("rst_pxl_addr", paddr0, 0);
        check("rst_wgt_addr", waddr0, 0);
        idle_bad = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            idle_bad += int'(done0) + int'(busy0);
        end
        check("post_reset_idle", idle_bad, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", busy0, 0);
        check("reset_done", done0, 0);
        check("reset_valid", vout0, 0);
        check("reset_rd_en", prd0, 0);
        check("reset_pxl_out", pout0, 0);
        check("reset_valid_small", vout1, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        run_pass(0, 0, -1);
        run_pass(0, 1, -1);
        run_pass(0, 3, -1);
        run_pass(0, 0, 5);
        for (int r = 0; r < 3; r++) run_pass(0, 2, -1);
        reset_mid_pass();
        run_pass(0, 0, -1);
        run_pass(1, 0, -1);
        run_pass(1, 2, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
